// File: rtl/io_uart_pkg.sv
// Shared constants for the memory-mapped UART: register selects, STATUS bit
// positions and the serialiser/deserialiser state encodings.
package io_uart_pkg;
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_BAUD   = 2'd2;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_VALID   = 2;
    localparam int ST_RX_FULL    = 3;
    localparam int ST_RX_OVERRUN = 4;
    localparam int ST_TX_BUSY    = 5;
    localparam int ST_FRAME_ERR  = 6;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
endpackage

// File: rtl/io_uart_fifo.sv
// Byte FIFO with extra-MSB pointers; a push into a full FIFO is accepted only
// when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_ONE;
            if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/io_uart.sv
// Memory-mapped UART: DATA/STATUS/BAUD_DIV registers, TX FIFO + serialiser,
// synchronised RX deserialiser + RX FIFO, and a level interrupt.
module io_uart
    import io_uart_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 434,
    parameter int DIV_WIDTH    = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        io_writen,
    input  logic        io_readn,
    input  logic [31:0] io_address,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    input  logic        uart_rxd,
    output logic        uart_txd,
    output logic        irq
);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(2);

    logic [1:0] sel;
    logic       wr, rd, unused_bits;
    logic       tx_full, tx_empty, tx_pop, rx_full, rx_empty, rx_pop, rx_push;
    logic [7:0] tx_head, rx_head;
    logic       ovr_set, ferr_set, ovr_q, ferr_q;
    logic [DIV_WIDTH-1:0] baud_q, wr_div;
    logic [6:0] status;

    tx_state_e            tx_state_q, tx_state_d;
    logic [DIV_WIDTH-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [7:0]           tx_shift_q, tx_shift_d;
    logic                 txd_q, txd_d;

    rx_state_e            rx_state_q, rx_state_d;
    logic [DIV_WIDTH-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [7:0]           rx_shift_q, rx_shift_d;
    logic                 rx_s1_q, rx_s2_q, rx_prev_q;

    assign sel         = io_address[3:2];
    assign wr          = !io_writen;
    assign rd          = !io_readn;
    assign rx_pop      = rd && (sel == REG_DATA);
    assign unused_bits = ^{io_address[31:4], io_address[1:0], io_wdata};
    assign wr_div      = (io_wdata[DIV_WIDTH-1:0] < DIV_MIN) ? DIV_MIN : io_wdata[DIV_WIDTH-1:0];
    assign uart_txd    = txd_q;
    assign irq         = !rx_empty || tx_empty;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .clr(clr), .push(wr && (sel == REG_DATA)), .wdata(io_wdata[7:0]),
        .pop(tx_pop), .full(tx_full), .empty(tx_empty), .head(tx_head)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .clr(clr), .push(rx_push), .wdata(rx_shift_q),
        .pop(rx_pop), .full(rx_full), .empty(rx_empty), .head(rx_head)
    );

    always_comb begin
        status                = '0;
        status[ST_TX_FULL]    = tx_full;
        status[ST_TX_EMPTY]   = tx_empty;
        status[ST_RX_VALID]   = !rx_empty;
        status[ST_RX_FULL]    = rx_full;
        status[ST_RX_OVERRUN] = ovr_q;
        status[ST_TX_BUSY]    = (tx_state_q != TX_IDLE);
        status[ST_FRAME_ERR]  = ferr_q;
        case (sel)
            REG_DATA:   io_rdata = {24'b0, rx_empty ? 8'h00 : rx_head};
            REG_STATUS: io_rdata = {25'b0, status};
            REG_BAUD:   io_rdata = {{(32-DIV_WIDTH){1'b0}}, baud_q};
            default:    io_rdata = '0;
        endcase
    end

    // A sticky bit set on the same edge as its write-1-to-clear stays set.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            baud_q <= DIV_WIDTH'(CLKS_PER_BIT);
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            if (wr && (sel == REG_BAUD)) baud_q <= wr_div;
            if (ovr_set) ovr_q <= 1'b1;
            else if (wr && (sel == REG_STATUS) && io_wdata[ST_RX_OVERRUN]) ovr_q <= 1'b0;
            if (ferr_set) ferr_q <= 1'b1;
            else if (wr && (sel == REG_STATUS) && io_wdata[ST_FRAME_ERR]) ferr_q <= 1'b0;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        tx_pop     = 1'b0;
        if (tx_state_q != TX_IDLE && tx_cnt_q != DIV_ONE) begin
            tx_cnt_d = tx_cnt_q - DIV_ONE;
        end else begin
            case (tx_state_q)
                TX_START: begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = baud_q;
                    tx_bit_d   = 3'd0;
                    txd_d      = tx_shift_q[0];
                end
                TX_DATA: begin
                    tx_cnt_d = baud_q;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_shift_d = tx_shift_q >> 1;
                        txd_d      = tx_shift_q[1];
                        tx_bit_d   = tx_bit_q + 3'd1;
                    end
                end
                default: begin
                    // IDLE, or the last clock of STOP: chain straight into the next frame.
                    tx_state_d = TX_IDLE;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        tx_cnt_d   = baud_q;
                        tx_state_d = TX_START;
                        txd_d      = 1'b0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        ovr_set    = 1'b0;
        ferr_set   = 1'b0;
        if (rx_state_q == RX_IDLE) begin
            // Needs a high-to-low edge, so after a framing error the line must rise first.
            if (rx_prev_q && !rx_s2_q) begin
                rx_state_d = RX_START;
                rx_cnt_d   = baud_q >> 1;
            end
        end else if (rx_cnt_q != DIV_ONE) begin
            rx_cnt_d = rx_cnt_q - DIV_ONE;
        end else begin
            rx_cnt_d = baud_q;
            case (rx_state_q)
                RX_START: begin
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                    rx_bit_d   = 3'd0;
                end
                RX_DATA: begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
                default: begin
                    rx_state_d = RX_IDLE;
                    if (!rx_s2_q)                  ferr_set = 1'b1;
                    else if (rx_full && !rx_pop)   ovr_set  = 1'b1;
                    else                           rx_push  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= DIV_ONE;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            txd_q      <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= DIV_ONE;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_s1_q    <= uart_rxd;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
        end
    end
endmodule

// File: tb/tb_io_uart.sv
// Bench for io_uart: frame-timeline model of the transmitter checked every
// cycle, plus directed register, loopback, RX and boundary vectors.
module tb_io_uart;
    localparam int DEPTH = 16;
    localparam logic [31:0] BASE = 32'ha000_0000;

    logic clk = 1'b0;
    logic clr, io_writen, io_readn, uart_rxd, uart_txd, irq, rx_drv, lb;
    logic [31:0] io_address, io_wdata, io_rdata;
    int total = 0;
    int bad = 0;

    assign uart_rxd = lb ? uart_txd : rx_drv;
    always #5 clk = ~clk;

    io_uart #(.FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(434), .DIV_WIDTH(16)) dut (
        .clk(clk), .clr(clr), .io_writen(io_writen), .io_readn(io_readn),
        .io_address(io_address), .io_wdata(io_wdata), .io_rdata(io_rdata),
        .uart_rxd(uart_rxd), .uart_txd(uart_txd), .irq(irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Transmitter model: a byte queue and the frame currently on the line,
    // addressed by clocks elapsed since the frame began.
    logic [7:0] m_q[$];
    logic [7:0] m_byte = 8'h00;
    int  m_k = 0;
    int  m_div = 434;
    bit  m_busy = 1'b0;

    function automatic logic m_txd();
        int b;
        if (!m_busy) return 1'b1;
        b = m_k / m_div;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_byte[b-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_txbits();
        return {26'b0, m_busy, 3'b000, (m_q.size() == 0), (m_q.size() == DEPTH)};
    endfunction

    // Compare against the state left by the last rising edge, then advance the
    // model across the coming edge using the inputs that edge will see.
    always @(negedge clk) begin : model_p
        bit pop_now, push_ok;
        if (clr) begin
            m_q.delete();
            m_busy = 1'b0;
            m_k = 0;
            m_div = 434;
        end
        chk("txd_line", {31'b0, uart_txd}, {31'b0, m_txd()});
        if (!clr) begin
            pop_now = 1'b0;
            if (m_busy) begin
                m_k++;
                if (m_k == 10 * m_div) m_busy = 1'b0;
            end
            if (!m_busy && m_q.size() > 0) pop_now = 1'b1;
            push_ok = !io_writen && io_address[3:2] == 2'd0 && (m_q.size() < DEPTH || pop_now);
            if (pop_now) begin
                m_byte = m_q.pop_front();
                m_busy = 1'b1;
                m_k = 0;
            end
            if (push_ok) m_q.push_back(io_wdata[7:0]);
            if (!io_writen && io_address[3:2] == 2'd2)
                m_div = (io_wdata[15:0] < 16'd2) ? 2 : int'(io_wdata[15:0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [31:0] d);
        io_address = BASE | {28'b0, sel, 2'b00};
        io_wdata = d;
        io_writen = 1'b0;
        tick();
        io_writen = 1'b1;
    endtask

    task automatic rd(input logic [1:0] sel, output logic [31:0] d);
        io_address = BASE | {28'b0, sel, 2'b00};
        io_readn = 1'b0;
        #3;
        d = io_rdata;
        tick();
        io_readn = 1'b1;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] sel, input logic [31:0] exp);
        logic [31:0] d;
        io_address = BASE | {28'b0, sel, 2'b00};
        #3;
        if (sel == 2'd1) exp = exp | m_txbits();
        #0;
        io_address = io_address;
        io_readn = 1'b0;
        d = io_rdata;
        tick();
        io_readn = 1'b1;
        chk(name, d, exp);
    endtask

    // Drive one serial frame; optionally read DATA so the read commits on edge
    // pop_at counted from the edge before the start bit.
    task automatic send_rx(input logic [7:0] b, input logic stopb, input int div,
                           input int pop_at, input logic [7:0] exp_head);
        logic [9:0] f;
        f = {stopb, b, 1'b0};
        for (int c = 0; c < 10 * div + 3; c++) begin
            rx_drv = (c < 10 * div) ? f[c / div] : 1'b1;
            if (c + 1 == pop_at) begin
                io_address = BASE;
                io_readn = 1'b0;
                #3;
                chk("same_edge_pop_head", io_rdata, {24'b0, exp_head});
            end
            tick();
            if (c + 1 == pop_at) io_readn = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [9:0] lit;
        clr = 1'b1; io_writen = 1'b1; io_readn = 1'b1; io_address = BASE;
        io_wdata = '0; rx_drv = 1'b1; lb = 1'b0;
        repeat (3) tick();
        clr = 1'b0;
        tick();
        rd_chk("por_status", 2'd1, 32'h0000_0002);
        rd_chk("por_baud", 2'd2, 32'd434);
        chk("por_irq", {31'b0, irq}, 32'd1);

        // Reset in the middle of a frame
        wr(2'd2, 32'd4);
        wr(2'd0, 32'h0000_00C3);
        repeat (2) tick();
        chk("txd_start_before_reset", {31'b0, uart_txd}, 32'd0);
        clr = 1'b1;
        #1;
        chk("txd_in_reset", {31'b0, uart_txd}, 32'd1);
        chk("irq_in_reset", {31'b0, irq}, 32'd1);
        @(posedge clk); #1;
        clr = 1'b0;
        rd(2'd1, d);
        chk("reset_status_0x02", d, 32'h0000_0002);
        rd(2'd2, d);
        chk("reset_baud_434", d, 32'd434);
        chk("reset_irq", {31'b0, irq}, 32'd1);

        // Loopback of 0x5A at BAUD_DIV=4; lit is the frame LSB (start) first
        wr(2'd2, 32'd4);
        lb = 1'b1;
        wr(2'd0, 32'h0000_005A);
        lit = 10'b1010110100;
        @(negedge clk);
        chk("lb_idle_before_start", {31'b0, uart_txd}, 32'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk($sformatf("lb_bit%0d_clk%0d", i / 4, i % 4), {31'b0, uart_txd}, {31'b0, lit[i / 4]});
        end
        @(posedge clk); #1;
        repeat (4) tick();
        rd(2'd1, d);
        chk("lb_status_rx_valid", d, 32'h0000_0006);
        rd(2'd0, d);
        chk("lb_data_5a", d, 32'h0000_005A);
        rd(2'd1, d);
        chk("lb_status_after_pop", d, 32'h0000_0002);
        lb = 1'b0;

        // 17 back-to-back TX writes into a 16-deep FIFO
        for (int i = 0; i < 16; i++) wr(2'd0, i);
        rd(2'd1, d);
        chk("tx16_not_full", d, 32'h0000_0020);
        wr(2'd0, 32'd16);
        rd(2'd1, d);
        chk("tx17_full", d, 32'h0000_0021);
        chk("irq_low_tx_pending", {31'b0, irq}, 32'd0);
        wr(2'd0, 32'h0000_00EE);
        rd_chk("tx_full_after_drop", 2'd1, 32'h0);
        repeat (700) tick();
        rd(2'd1, d);
        chk("tx_drained", d, 32'h0000_0002);

        // 17 RX frames without reading
        for (int i = 0; i < 16; i++) send_rx(8'h30 + 8'(i), 1'b1, 4, 0, 8'h00);
        rd(2'd1, d);
        chk("rx16_full", d, 32'h0000_000E);
        send_rx(8'h40, 1'b1, 4, 0, 8'h00);
        rd(2'd1, d);
        chk("rx17_overrun_bits", d & 32'h0000_001C, 32'h0000_001C);
        chk("rx17_status", d, 32'h0000_001E);
        wr(2'd1, 32'h0000_0010);
        rd(2'd1, d);
        chk("overrun_cleared", d, 32'h0000_000E);
        for (int i = 0; i < 16; i++) begin
            rd(2'd0, d);
            chk($sformatf("rx_byte%0d", i), d, 32'h30 + i);
        end
        rd(2'd1, d);
        chk("rx_drained", d, 32'h0000_0002);
        rd(2'd0, d);
        chk("rx_empty_read_0", d, 32'h0);

        // Framing error, then a one-clock glitch
        send_rx(8'h77, 1'b0, 4, 0, 8'h00);
        rd(2'd1, d);
        chk("frame_err_status", d, 32'h0000_0042);
        rd(2'd0, d);
        chk("frame_err_no_push", d, 32'h0);
        wr(2'd1, 32'h0000_0040);
        rd(2'd1, d);
        chk("frame_err_cleared", d, 32'h0000_0002);
        rx_drv = 1'b0;
        tick();
        rx_drv = 1'b1;
        repeat (20) tick();
        rd(2'd1, d);
        chk("glitch_ignored", d, 32'h0000_0002);

        // BAUD_DIV written as 0 is clamped to 2
        wr(2'd2, 32'd0);
        rd(2'd2, d);
        chk("baud_clamped_2", d, 32'd2);
        wr(2'd0, 32'h0000_00A5);
        @(negedge clk);
        chk("div2_pre", {31'b0, uart_txd}, 32'd1);
        @(negedge clk);
        chk("div2_start_a", {31'b0, uart_txd}, 32'd0);
        @(negedge clk);
        chk("div2_start_b", {31'b0, uart_txd}, 32'd0);
        @(negedge clk);
        chk("div2_d0_a", {31'b0, uart_txd}, 32'd1);
        @(negedge clk);
        chk("div2_d0_b", {31'b0, uart_txd}, 32'd1);
        @(negedge clk);
        chk("div2_d1_a", {31'b0, uart_txd}, 32'd0);
        @(posedge clk); #1;
        repeat (25) tick();

        // RX push and CPU pop on the same edge with one entry queued
        send_rx(8'h11, 1'b1, 2, 0, 8'h00);
        rd(2'd1, d);
        chk("one_entry_status", d, 32'h0000_0006);
        send_rx(8'h22, 1'b1, 2, 22, 8'h11);
        rd(2'd1, d);
        chk("count_still_one", d, 32'h0000_0006);
        rd(2'd0, d);
        chk("second_byte_22", d, 32'h0000_0022);
        rd(2'd1, d);
        chk("final_empty", d, 32'h0000_0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
